// File: rtl/frame_line_fetcher_if.sv
// -----------------------------------------------------------------------------
// frame_line_fetcher_if
//   SRAM read port between the line fetcher and the SRAM controller arbiter.
//
//   rd_req   requester -> arbiter   read request, held until acknowledged
//   rd_addr  requester -> arbiter   SRAM word address, valid while rd_req=1
//   rd_ack   arbiter -> requester   one-cycle pulse, rd_data valid same cycle
//   rd_data  arbiter -> requester   16-bit read data
//
//   master : the requester (frame_line_fetcher)
//   slave  : the SRAM controller arbiter
// -----------------------------------------------------------------------------
interface frame_line_fetcher_if;
   logic        rd_req;
   logic [19:0] rd_addr;
   logic        rd_ack;
   logic [15:0] rd_data;

   modport master (output rd_req, rd_addr, input rd_ack, rd_data);
   modport slave  (input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/frame_line_fetcher.sv
// -----------------------------------------------------------------------------
// frame_line_fetcher
//   Prefetches the next scanline from the SRAM frame buffer into one of two
//   ping-pong line buffers (buffer = line parity) and serves 16-bit pixels to
//   the VGA colour path, two clocks after the scan position.
//
//   clk       system clock
//   reset     synchronous, active-high
//   vga_x     current scan column
//   vga_y     current scan line
//   vga_data  registered pixel colour (0 outside the active area)
//   underrun  sticky: a pixel was not ready, or a fetch was overrun
//   sram      SRAM read port (master side)
// -----------------------------------------------------------------------------
module frame_line_fetcher #(
   parameter int          H_ACTIVE       = 640,
   parameter int          V_ACTIVE       = 480,
   parameter int          V_TOTAL        = 525,
   parameter logic [19:0] FB_BASE        = 20'h00000,
   parameter logic [15:0] UNDERRUN_COLOR = 16'hF81F
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [9:0]           vga_x,
   input  logic [9:0]           vga_y,
   output logic [15:0]          vga_data,
   output logic                 underrun,
   frame_line_fetcher_if.master sram
);

   localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] B1_OFS = 11'(H_ACTIVE);

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

   // Word address of the first pixel of a line; line*640 as two shifts.
   function automatic logic [19:0] line_base(input logic [9:0] line);
      return FB_BASE + (20'(line) << 9) + (20'(line) << 7);
   endfunction

   // ---------------------------------------------------------------- state
   state_e            state_q, state_d;
   logic [9:0]        prev_y_q, prev_y_d;
   logic [9:0]        tgt_q, tgt_d;
   logic              buf_q, buf_d;
   logic [9:0]        fill_q, fill_d;
   logic [1:0][9:0]   tag_q, tag_d;
   logic [1:0]        tag_vld_q, tag_vld_d;
   logic              underrun_q, underrun_d;
   logic [19:0]       rd_addr_q, rd_addr_d;

   // display pipeline
   logic              pix_blank_q, pix_blank_d;
   logic              pix_ok_q, pix_ok_d;
   logic [15:0]       vga_data_q, vga_data_d;
   logic [15:0]       ram_rd_q;

   // line buffer RAM: buffer 0 at [0..H-1], buffer 1 at [H..2H-1]
   logic [15:0]       line_mem [0:2*H_ACTIVE-1];
   logic              ram_we;
   logic [10:0]       ram_waddr;
   logic [10:0]       ram_raddr;

   // ------------------------------------------------------- new-line detect
   logic              new_line;
   logic [9:0]        nxt_tgt;
   logic              tgt_ok;

   assign new_line = (vga_y != prev_y_q);
   assign nxt_tgt  = (vga_y == V_LAST) ? 10'd0 : vga_y + 10'd1;
   assign tgt_ok   = (nxt_tgt < V_ACT);

   // ------------------------------------------------------------ fetch FSM
   always_comb begin
      state_d    = state_q;
      prev_y_d   = vga_y;
      tgt_d      = tgt_q;
      buf_d      = buf_q;
      fill_d     = fill_q;
      tag_d      = tag_q;
      tag_vld_d  = tag_vld_q;
      underrun_d = underrun_q;
      rd_addr_d  = rd_addr_q;
      ram_we     = 1'b0;
      ram_waddr  = buf_q ? B1_OFS + {1'b0, fill_q} : {1'b0, fill_q};

      case (state_q)
         IDLE: begin
            if (new_line && tgt_ok) begin
               state_d            = FETCH;
               tgt_d              = nxt_tgt;
               buf_d              = nxt_tgt[0];
               fill_d             = 10'd0;
               tag_vld_d[nxt_tgt[0]] = 1'b0;
               rd_addr_d          = line_base(nxt_tgt);
            end
         end
         FETCH: begin
            // A coincident ack always lands in the old buffer slot first.
            ram_we = sram.rd_ack;
            if (new_line) begin
               // Overrun: the partial line is dropped, its tag stays invalid.
               underrun_d = 1'b1;
               if (tgt_ok) begin
                  tgt_d              = nxt_tgt;
                  buf_d              = nxt_tgt[0];
                  fill_d             = 10'd0;
                  tag_vld_d[nxt_tgt[0]] = 1'b0;
                  rd_addr_d          = line_base(nxt_tgt);
               end else begin
                  state_d = IDLE;
               end
            end else if (sram.rd_ack) begin
               if (fill_q == H_LAST) begin
                  tag_d[buf_q]     = tgt_q;
                  tag_vld_d[buf_q] = 1'b1;
                  state_d          = IDLE;
               end else begin
                  fill_d    = fill_q + 10'd1;
                  rd_addr_d = rd_addr_q + 20'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // ------------------------------------------------------ display path
      pix_blank_d = (vga_x >= H_ACT) || (vga_y >= V_ACT);
      // Valid from a completed buffer, or from the part of the buffer being
      // filled for this very line that has already been written.
      pix_ok_d = (tag_vld_q[vga_y[0]] && (tag_q[vga_y[0]] == vga_y)) ||
                 ((state_q == FETCH) && (buf_q == vga_y[0]) &&
                  (tgt_q == vga_y) && (vga_x < fill_q));
      ram_raddr = pix_blank_d ? 11'd0 :
                  (vga_y[0] ? B1_OFS + {1'b0, vga_x} : {1'b0, vga_x});

      if (pix_blank_q)
         vga_data_d = 16'h0000;
      else if (pix_ok_q)
         vga_data_d = ram_rd_q;
      else begin
         vga_data_d = UNDERRUN_COLOR;
         underrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         prev_y_q    <= 10'h3FF;
         tgt_q       <= 10'd0;
         buf_q       <= 1'b0;
         fill_q      <= 10'd0;
         tag_q       <= '0;
         tag_vld_q   <= 2'b00;
         underrun_q  <= 1'b0;
         rd_addr_q   <= 20'd0;
         pix_blank_q <= 1'b1;
         pix_ok_q    <= 1'b0;
         vga_data_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         prev_y_q    <= prev_y_d;
         tgt_q       <= tgt_d;
         buf_q       <= buf_d;
         fill_q      <= fill_d;
         tag_q       <= tag_d;
         tag_vld_q   <= tag_vld_d;
         underrun_q  <= underrun_d;
         rd_addr_q   <= rd_addr_d;
         pix_blank_q <= pix_blank_d;
         pix_ok_q    <= pix_ok_d;
         vga_data_q  <= vga_data_d;
      end
   end

   // Plain synchronous RAM, no reset, so it maps onto block memory.
   always_ff @(posedge clk) begin
      if (ram_we)
         line_mem[ram_waddr] <= sram.rd_data;
      ram_rd_q <= line_mem[ram_raddr];
   end

   assign sram.rd_req  = (state_q == FETCH);
   assign sram.rd_addr = rd_addr_q;
   assign vga_data     = vga_data_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_frame_line_fetcher.sv
module tb_frame_line_fetcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  vga_x = 10'd700;
   logic [9:0]  vga_y = 10'd523;
   logic [15:0] vga_data;
   logic        underrun;

   frame_line_fetcher_if sram_if ();

   frame_line_fetcher dut (
      .clk      (clk),
      .reset    (reset),
      .vga_x    (vga_x),
      .vga_y    (vga_y),
      .vga_data (vga_data),
      .underrun (underrun),
      .sram     (sram_if)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // SRAM model: data = low 16 bits of the address
   bit          ack_en    = 1'b0;
   int          ack_delay = 0;
   int          ack_cnt   = 0;
   logic [19:0] acked_q[$];
   logic [19:0] exp_addr_q[$];

   typedef struct packed {logic chk; logic [15:0] e;} lag_t;
   lag_t        lag_q[$];
   logic [15:0] pe_q[$];
   logic [15:0] po_q[$];

   initial begin
      int wait_cnt;
      wait_cnt = 0;
      sram_if.rd_ack  = 1'b0;
      sram_if.rd_data = 16'h0;
      forever begin
         @(negedge clk);
         sram_if.rd_ack = 1'b0;
         if (ack_en && sram_if.rd_req && !reset) begin
            if (wait_cnt >= ack_delay) begin
               sram_if.rd_ack  = 1'b1;
               sram_if.rd_data = sram_if.rd_addr[15:0];
               acked_q.push_back(sram_if.rd_addr);
               ack_cnt++;
               wait_cnt = 0;
            end else
               wait_cnt++;
         end else
            wait_cnt = 0;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input int limit, output bit ok);
      int n;
      n = 0;
      cyc(2);
      while (sram_if.rd_req && n < limit) begin
         cyc(1);
         n++;
      end
      ok = !sram_if.rd_req;
   endtask

   // One scan cycle: collect the output for the input driven two cycles ago,
   // then drive the new position and queue its expected pixel.
   task automatic pix_cycle(input logic [9:0] x, input logic [9:0] y,
                            input logic [15:0] e, input logic chk);
      lag_t ent;
      @(negedge clk);
      if (lag_q.size() == 2) begin
         ent = lag_q.pop_front();
         if (ent.chk) begin
            pe_q.push_back(ent.e);
            po_q.push_back(vga_data);
         end
      end
      vga_x = x;
      vga_y = y;
      lag_q.push_back({chk, e});
   endtask

   task automatic start_pix();
      lag_q.delete();
      pe_q.delete();
      po_q.delete();
   endtask

   task automatic push_line_addrs(input int line);
      exp_addr_q.delete();
      for (int i = 0; i < 640; i++) exp_addr_q.push_back(20'(line * 640 + i));
   endtask

   task automatic test_reset();
      reset = 1'b1; ack_en = 1'b0; vga_x = 10'd700; vga_y = 10'd523;
      cyc(3);
      checks++; if (vga_data !== 16'h0) begin errors++; $display("FAIL reset_vga_data: got %h expected 0000", vga_data); end
      checks++; if (sram_if.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b expected 0", sram_if.rd_req); end
      checks++; if (sram_if.rd_addr !== 20'h0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 00000", sram_if.rd_addr); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
      reset = 1'b0;
      cyc(4);
      checks++; if (sram_if.rd_req !== 1'b0) begin errors++; $display("FAIL no_fetch_523: got rd_req %b expected 0", sram_if.rd_req); end
   endtask

   task automatic test_fetch_line0();
      bit ok;
      logic [19:0] a, e;
      acked_q.delete();
      push_line_addrs(0);
      ack_delay = 0; ack_en = 1'b1;
      vga_y = 10'd524;
      wait_done(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fetch0_done: rd_req still %b, expected 0", sram_if.rd_req); end
      checks++; if (acked_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL fetch0_count: got %0d acks expected %0d", acked_q.size(), exp_addr_q.size()); end
      while (acked_q.size() > 0 && exp_addr_q.size() > 0) begin
         a = acked_q.pop_front(); e = exp_addr_q.pop_front();
         checks++; if (a !== e) begin errors++; $display("FAIL fetch0_addr: got %h expected %h", a, e); end
      end
   endtask

   task automatic test_display_line0();
      logic [15:0] o, e;
      start_pix();
      for (int x = 0; x < 640; x++) begin
         pix_cycle(10'(x), 10'd0, 16'(x), 1'b1);
         pix_cycle(10'(x), 10'd0, 16'(x), 1'b1);
      end
      pix_cycle(10'd700, 10'd0, 16'h0, 1'b1);
      pix_cycle(10'd700, 10'd0, 16'h0, 1'b1);
      pix_cycle(10'd700, 10'd0, 16'h0, 1'b0);
      pix_cycle(10'd700, 10'd0, 16'h0, 1'b0);
      checks++; if (pe_q.size() != 1282) begin errors++; $display("FAIL disp0_count: got %0d samples expected 1282", pe_q.size()); end
      while (pe_q.size() > 0) begin
         e = pe_q.pop_front(); o = po_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL disp0_pixel: got %h expected %h", o, e); end
      end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL disp0_underrun: got %b expected 0", underrun); end
   endtask

   task automatic test_line_base();
      bit ok;
      logic [19:0] a, e;
      logic [15:0] o, pe;
      int xs[4] = '{0, 1, 320, 639};
      wait_done(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL line1_done: rd_req %b expected 0", sram_if.rd_req); end
      vga_y = 10'd9;
      wait_done(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL line10_done: rd_req %b expected 0", sram_if.rd_req); end
      ack_en = 1'b0;
      acked_q.delete();
      push_line_addrs(11);
      vga_y = 10'd10;
      cyc(2);
      checks++; if (sram_if.rd_req !== 1'b1) begin errors++; $display("FAIL line11_req: got %b expected 1", sram_if.rd_req); end
      checks++; if (sram_if.rd_addr !== 20'h01B80) begin errors++; $display("FAIL line11_base: got %h expected 01b80", sram_if.rd_addr); end
      ack_en = 1'b1;
      wait_done(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL line11_done: rd_req %b expected 0", sram_if.rd_req); end
      while (acked_q.size() > 0 && exp_addr_q.size() > 0) begin
         a = acked_q.pop_front(); e = exp_addr_q.pop_front();
         checks++; if (a !== e) begin errors++; $display("FAIL line11_addr: got %h expected %h", a, e); end
      end
      checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL line11_count: %0d addresses never acked, expected 0", exp_addr_q.size()); end
      // line 11 must come out of buffer 1 while line 12 fills buffer 0
      start_pix();
      foreach (xs[i]) begin
         pix_cycle(10'(xs[i]), 10'd11, 16'(7040 + xs[i]), 1'b1);
         pix_cycle(10'(xs[i]), 10'd11, 16'(7040 + xs[i]), 1'b1);
      end
      pix_cycle(10'd700, 10'd11, 16'h0, 1'b0);
      pix_cycle(10'd700, 10'd11, 16'h0, 1'b0);
      while (pe_q.size() > 0) begin
         pe = pe_q.pop_front(); o = po_q.pop_front();
         checks++; if (o !== pe) begin errors++; $display("FAIL disp11_pixel: got %h expected %h", o, pe); end
      end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL disp11_underrun: got %b expected 0", underrun); end
   endtask

   task automatic test_overrun();
      bit ok;
      int n;
      logic [15:0] o, pe;
      int xs[3] = '{200, 400, 639};
      wait_done(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL line12_done: rd_req %b expected 0", sram_if.rd_req); end
      ack_delay = 3; ack_cnt = 0;
      vga_y = 10'd19;
      n = 0;
      while (ack_cnt < 200 && n < 5000) begin cyc(1); n++; end
      checks++; if (ack_cnt < 200) begin errors++; $display("FAIL overrun_progress: got %0d acks expected 200", ack_cnt); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL pre_overrun_underrun: got %b expected 0", underrun); end
      vga_y = 10'd20;
      cyc(1);
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", underrun); end
      checks++; if (sram_if.rd_req !== 1'b1) begin errors++; $display("FAIL overrun_req: got %b expected 1", sram_if.rd_req); end
      checks++; if (sram_if.rd_addr !== 20'h03480) begin errors++; $display("FAIL overrun_restart_addr: got %h expected 03480", sram_if.rd_addr); end
      start_pix();
      foreach (xs[i]) begin
         pix_cycle(10'(xs[i]), 10'd20, 16'hF81F, 1'b1);
         pix_cycle(10'(xs[i]), 10'd20, 16'hF81F, 1'b1);
      end
      pix_cycle(10'd700, 10'd20, 16'h0, 1'b0);
      pix_cycle(10'd700, 10'd20, 16'h0, 1'b0);
      while (pe_q.size() > 0) begin
         pe = pe_q.pop_front(); o = po_q.pop_front();
         checks++; if (o !== pe) begin errors++; $display("FAIL overrun_pixel: got %h expected %h", o, pe); end
      end
   endtask

   task automatic test_blank();
      bit ok;
      logic [15:0] o, pe;
      wait_done(6000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL line21_done: rd_req %b expected 0", sram_if.rd_req); end
      ack_delay = 0;
      start_pix();
      pix_cycle(10'd700, 10'd20, 16'h0, 1'b1);
      pix_cycle(10'd700, 10'd20, 16'h0, 1'b1);
      pix_cycle(10'd5, 10'd490, 16'h0, 1'b1);
      pix_cycle(10'd5, 10'd490, 16'h0, 1'b1);
      pix_cycle(10'd700, 10'd490, 16'h0, 1'b0);
      pix_cycle(10'd700, 10'd490, 16'h0, 1'b0);
      while (pe_q.size() > 0) begin
         pe = pe_q.pop_front(); o = po_q.pop_front();
         checks++; if (o !== pe) begin errors++; $display("FAIL blank_pixel: got %h expected %h", o, pe); end
      end
      for (int y = 480; y < 524; y++) begin
         vga_y = 10'(y);
         cyc(2);
         checks++; if (sram_if.rd_req !== 1'b0) begin errors++; $display("FAIL vblank_no_fetch y=%0d: got rd_req %b expected 0", y, sram_if.rd_req); end
      end
   endtask

   task automatic test_reset_mid_fetch();
      bit ok;
      int n;
      logic [19:0] a, e;
      logic [15:0] o, pe;
      int xs[2] = '{0, 639};
      ack_delay = 0; ack_cnt = 0;
      vga_x = 10'd700; vga_y = 10'd299;
      n = 0;
      while (ack_cnt < 300 && n < 2000) begin cyc(1); n++; end
      checks++; if (ack_cnt < 300) begin errors++; $display("FAIL midfetch_progress: got %0d acks expected 300", ack_cnt); end
      reset = 1'b1;
      cyc(1);
      checks++; if (sram_if.rd_req !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b expected 0", sram_if.rd_req); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midreset_underrun: got %b expected 0", underrun); end
      checks++; if (vga_data !== 16'h0) begin errors++; $display("FAIL midreset_vga_data: got %h expected 0000", vga_data); end
      cyc(1);
      reset = 1'b0;
      acked_q.delete();
      push_line_addrs(300);
      cyc(1);
      checks++; if (sram_if.rd_req !== 1'b1) begin errors++; $display("FAIL refetch_req: got %b expected 1", sram_if.rd_req); end
      checks++; if (sram_if.rd_addr !== 20'h2EE00) begin errors++; $display("FAIL refetch_base: got %h expected 2ee00", sram_if.rd_addr); end
      wait_done(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL refetch_done: rd_req %b expected 0", sram_if.rd_req); end
      while (acked_q.size() > 0 && exp_addr_q.size() > 0) begin
         a = acked_q.pop_front(); e = exp_addr_q.pop_front();
         checks++; if (a !== e) begin errors++; $display("FAIL refetch_addr: got %h expected %h", a, e); end
      end
      checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL refetch_count: %0d addresses never acked, expected 0", exp_addr_q.size()); end
      start_pix();
      foreach (xs[i]) begin
         pix_cycle(10'(xs[i]), 10'd300, 16'(192000 + xs[i]), 1'b1);
         pix_cycle(10'(xs[i]), 10'd300, 16'(192000 + xs[i]), 1'b1);
      end
      pix_cycle(10'd700, 10'd300, 16'h0, 1'b0);
      pix_cycle(10'd700, 10'd300, 16'h0, 1'b0);
      while (pe_q.size() > 0) begin
         pe = pe_q.pop_front(); o = po_q.pop_front();
         checks++; if (o !== pe) begin errors++; $display("FAIL disp300_pixel: got %h expected %h", o, pe); end
      end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL disp300_underrun: got %b expected 0", underrun); end
   endtask

   initial begin
      test_reset();
      test_fetch_line0();
      test_display_line0();
      test_line_base();
      test_overrun();
      test_blank();
      test_reset_mid_fetch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
